// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, drives the instruction-memory read request, and owns the
// IF/ID pipeline register that feeds the decoder. A one-entry skid buffer
// absorbs an instruction returned while decode is stalled. Branch/jump
// redirects squash younger work, and fetch stops after a HALT opcode.
//
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   iREN, iaddr          instruction read enable / address (iaddr == PC)
//   ihit, iload          memory response valid / instruction word
//   stall                decode cannot accept; IF/ID holds
//   redirect, target     taken branch/jump and its destination
//   ifid_valid/instr/pc/npc  IF/ID register contents
//   halted               HALT fetched, fetch stopped
//
// Flow state is implied by two flags rather than an explicit encoding:
//   FETCH  = !skid_valid && !halted
//   FULL   =  skid_valid
//   HALTED =  halted
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        halted
);

    logic [31:0] pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        accept;
    logic        is_halt;

    // No new request while the skid is occupied: that guarantees the skid
    // is never filled and drained in the same cycle.
    assign iREN    = !RST && !halted && !skid_valid;
    assign accept  = iREN && ihit && !redirect;
    assign is_halt = (iload[31:26] == HALT_OP);
    assign iaddr   = pc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc         <= PC_INIT;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_npc   <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            halted     <= 1'b0;
        end else if (redirect) begin
            // Squash wins over stall and over a HALT accepted this cycle.
            pc         <= {target[31:2], 2'b00};
            ifid_valid <= 1'b0;
            skid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
                if (is_halt)
                    halted <= 1'b1;
            end

            if (!stall) begin
                if (skid_valid) begin
                    ifid_valid <= 1'b1;
                    ifid_instr <= skid_instr;
                    ifid_pc    <= skid_pc;
                    ifid_npc   <= skid_pc + 32'd4;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    ifid_valid <= 1'b1;
                    ifid_instr <= iload;
                    ifid_pc    <= pc;
                    ifid_npc   <= pc + 32'd4;
                end else begin
                    ifid_valid <= 1'b0;
                end
            end else if (accept) begin
                // Decode is stalled: park the returned word in the skid.
                skid_valid <= 1'b1;
                skid_instr <= iload;
                skid_pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed walk through the fetch scenarios
// followed by randomized traffic, all checked against a queue-based
// reference model of fetched-but-undelivered instructions.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST, iREN, ihit, stall, redirect, ifid_valid, halted;
    logic [31:0] iaddr, iload, target, ifid_instr, ifid_pc, ifid_npc;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr),
        .ihit(ihit), .iload(iload), .stall(stall),
        .redirect(redirect), .target(target),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_npc(ifid_npc), .halted(halted)
    );

    // Reference model: fetched words waiting for decode live in a queue;
    // the stage may only issue a new request while that queue is empty.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_v, m_halt;
    bit          m_init = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        if (!m_init) return;
        chk("iREN", {31'd0, iREN}, {31'd0, (!RST && !m_halt && q.size() == 0)});
        chk("iaddr", iaddr, m_pc);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        if (m_v) begin
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_npc", ifid_npc, m_ipc + 32'd4);
        end
    endtask

    task automatic model_step();
        bit   take;
        ent_t e;
        if (RST) begin
            m_pc = 32'h0; m_v = 0; m_instr = 0; m_ipc = 0;
            m_halt = 0; m_init = 1; q.delete();
        end else if (redirect) begin
            q.delete();
            m_v    = 0;
            m_halt = 0;
            m_pc   = target & 32'hFFFF_FFFC;
        end else begin
            take = !m_halt && q.size() == 0 && ihit;
            if (!stall) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    m_v = 1; m_instr = e.instr; m_ipc = e.pc;
                end else if (take) begin
                    m_v = 1; m_instr = iload; m_ipc = m_pc;
                end else begin
                    m_v = 0;
                end
            end else if (take) begin
                e.instr = iload; e.pc = m_pc;
                q.push_back(e);
            end
            if (take) begin
                if (iload[31:26] == 6'h3F) m_halt = 1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: drive inputs, check outputs against the model, clock, update.
    task automatic cyc(input logic r, input logic h, input logic [31:0] ld,
                       input logic s, input logic rd, input logic [31:0] tg);
        RST = r; ihit = h; iload = ld; stall = s; redirect = rd; target = tg;
        #1;
        compare();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        logic [31:0] ld;
        // Reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_npc", ifid_npc, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        RST = 0; #1;
        chk("iren_after_rst", {31'd0, iREN}, 32'd1);

        // Straight line
        cyc(0, 1, 32'h2001_0005, 0, 0, 0);
        chk("sl_iaddr1", iaddr, 32'h4);
        chk("sl_instr1", ifid_instr, 32'h2001_0005);
        chk("sl_pc1", ifid_pc, 32'h0);
        chk("sl_npc1", ifid_npc, 32'h4);
        cyc(0, 1, 32'h2002_0006, 0, 0, 0);
        chk("sl_iaddr2", iaddr, 32'h8);
        chk("sl_instr2", ifid_instr, 32'h2002_0006);
        chk("sl_pc2", ifid_pc, 32'h4);
        chk("sl_npc2", ifid_npc, 32'h8);

        // Stall with skid: pc 8 lands in the skid, further hits are ignored
        cyc(0, 1, 32'h2003_0007, 1, 0, 0);
        chk("stall_pc_hold", ifid_pc, 32'h4);
        chk("stall_iaddr", iaddr, 32'hC);
        chk("stall_iren", {31'd0, iREN}, 32'd0);
        cyc(0, 1, 32'hDEAD_0001, 1, 0, 0);
        cyc(0, 1, 32'hDEAD_0002, 1, 0, 0);
        chk("stall_pc_hold3", ifid_pc, 32'h4);
        chk("stall_iaddr3", iaddr, 32'hC);
        cyc(0, 0, 0, 0, 0, 0);
        chk("release_pc", ifid_pc, 32'h8);
        chk("release_instr", ifid_instr, 32'h2003_0007);
        chk("release_iren", {31'd0, iREN}, 32'd1);
        cyc(0, 1, 32'h2004_000C, 0, 0, 0);
        chk("after_skid_pc", ifid_pc, 32'hC);

        // Redirect with simultaneous hit and stall
        cyc(0, 1, 32'h2005_0010, 1, 1, 32'h0000_0043);
        chk("redir_iaddr", iaddr, 32'h40);
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_skid_empty", {31'd0, iREN}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("redir_no_ghost", {31'd0, ifid_valid}, 32'd0);

        // Halt at 0x10
        cyc(0, 0, 0, 0, 1, 32'h10);
        cyc(0, 1, 32'hFC00_0000, 0, 0, 0);
        chk("halt_valid", {31'd0, ifid_valid}, 32'd1);
        chk("halt_instr", ifid_instr, 32'hFC00_0000);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_iren", {31'd0, iREN}, 32'd0);
        chk("halt_iaddr", iaddr, 32'h14);
        cyc(0, 1, 32'h2006_0000, 0, 0, 0);
        chk("halt_iaddr_hold", iaddr, 32'h14);
        cyc(0, 0, 0, 0, 1, 32'h20);
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_iaddr", iaddr, 32'h20);
        chk("unhalt_iren", {31'd0, iREN}, 32'd1);

        // Multi-cycle memory: three empty cycles, then the hit
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("mc_bubble", {31'd0, ifid_valid}, 32'd0);
            chk("mc_pc_hold", iaddr, 32'h20);
        end
        cyc(0, 1, 32'h2007_0000, 0, 0, 0);
        chk("mc_pc", ifid_pc, 32'h20);

        // Wrap
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h2008_0000, 0, 0, 0);
        chk("wrap_iaddr", iaddr, 32'h0);
        chk("wrap_npc", ifid_npc, 32'h0);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);

        // Reset with the skid full and halted set (HALT captured into skid)
        cyc(0, 1, 32'hFC00_0000, 1, 0, 0);
        chk("pre_rst_halted", {31'd0, halted}, 32'd1);
        cyc(1, 0, 0, 1, 0, 0);
        chk("mrst_iaddr", iaddr, 32'h0);
        chk("mrst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("mrst_instr", ifid_instr, 32'h0);
        chk("mrst_pc", ifid_pc, 32'h0);
        chk("mrst_npc", ifid_npc, 32'h0);
        chk("mrst_halted", {31'd0, halted}, 32'd0);
        chk("mrst_iren", {31'd0, iREN}, 32'd0);
        RST = 0; stall = 0; #1;
        chk("mrst_iren_after", {31'd0, iREN}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ld = $urandom;
            if ($urandom_range(0, 24) == 0) ld[31:26] = 6'h3F;
            else if (ld[31:26] == 6'h3F) ld[31:26] = 6'h08;
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, ld,
                $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom);
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
